// File: rtl/aes_byte_scanner_pkg.sv
// Shared widths, FSM state type and byte-select helper for the AES byte scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: NUM_BYTES/BYTE_W/IDX_W/BLOCK_W, state_t {EMPTY, SHOW}, block_byte().
package aes_byte_scanner_pkg;

   localparam int NUM_BYTES = 16;
   localparam int BYTE_W    = 8;
   localparam int IDX_W     = 4;
   localparam int BLOCK_W   = NUM_BYTES * BYTE_W;

   typedef enum logic {
      EMPTY = 1'b0,
      SHOW  = 1'b1
   } state_t;

   // Byte 0 is the most significant byte of the block, so shift the wanted
   // byte up to the top and take the top BYTE_W bits.
   function automatic logic [BYTE_W-1:0] block_byte(input logic [BLOCK_W-1:0] blk,
                                                    input logic [IDX_W-1:0]   idx);
      logic [BLOCK_W-1:0] sh;
      sh = blk << (BYTE_W * idx);
      return sh[BLOCK_W-1 -: BYTE_W];
   endfunction

endpackage

// File: rtl/aes_byte_scanner_if.sv
// Bus bundle between the AES block source / display and the byte scanner.
// Latency: n/a (wiring only).
// Backpressure: none; data_valid is a strobe, outputs are levels and pulses.
// master: drives data_in, data_valid, step_btn, auto_en; slave: drives
// byte_out, byte_idx, loaded, wrapped.
interface aes_byte_scanner_if;
   import aes_byte_scanner_pkg::*;

   logic [BLOCK_W-1:0] data_in;
   logic               data_valid;
   logic               step_btn;
   logic               auto_en;
   logic [BYTE_W-1:0]  byte_out;
   logic [IDX_W-1:0]   byte_idx;
   logic               loaded;
   logic               wrapped;

   modport master (
      output data_in, data_valid, step_btn, auto_en,
      input  byte_out, byte_idx, loaded, wrapped
   );

   modport slave (
      input  data_in, data_valid, step_btn, auto_en,
      output byte_out, byte_idx, loaded, wrapped
   );

endinterface

// File: rtl/aes_byte_scanner_button_debounce.sv
// Synchronises and debounces a raw push button, emits one pulse per accepted press.
// Latency: btn_rise is high 2 + DEBOUNCE_CYCLES + 1 cycles after the raw edge.
// Backpressure: none; a held button yields one pulse, release yields none.
// Ports: clk, rst (sync, active-high), btn_raw (async in), btn_level (accepted
// level), btn_rise (one-cycle pulse on accepted rising edge).
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_rise
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1;
   logic             sync2;
   logic             level_q;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         btn_level <= 1'b0;
         level_q   <= 1'b0;
         btn_rise  <= 1'b0;
         cnt       <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         // cnt counts consecutive cycles the synchronised level disagrees
         // with the accepted one; any agreeing cycle (a bounce) restarts it.
         if (sync2 != btn_level) begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               btn_level <= sync2;
               cnt       <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
         level_q  <= btn_level;
         btn_rise <= btn_level & ~level_q;
      end
   end

endmodule

// File: rtl/aes_byte_scanner.sv
// Captures a 128-bit AES block and presents it a byte at a time for a 7-seg display.
// Latency: byte_out follows byte_idx by one cycle; step advances 2+DEBOUNCE+1 cycles after press.
// Backpressure: none; data_valid always accepted and wins over step/tick in the same cycle.
// Ports: clk, rst (sync, active-high), bus (slave): data_in, data_valid, step_btn,
// auto_en in; byte_out, byte_idx, loaded, wrapped out (all registered).
module aes_byte_scanner
   import aes_byte_scanner_pkg::*;
#(
   parameter int TICK_DIV        = 50000000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic                clk,
   input  logic                rst,
   aes_byte_scanner_if.slave   bus
);

   localparam int PRE_W = $clog2(TICK_DIV);

   state_t             state;
   logic [BLOCK_W-1:0] shadow;
   logic [IDX_W-1:0]   idx;
   logic [PRE_W-1:0]   pre;
   logic [BYTE_W-1:0]  byte_q;
   logic               loaded_q;
   logic               wrapped_q;

   logic btn_level;
   logic btn_rise;
   logic step;
   logic tick;
   logic advance;

   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_button_debounce (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (bus.step_btn),
      .btn_level (btn_level),
      .btn_rise  (btn_rise)
   );

   // The rise pulse trails the accepted level by a cycle; qualifying it with
   // the level keeps a step from firing on a level that has already dropped.
   assign step    = btn_rise & btn_level;
   assign tick    = (state == SHOW) && bus.auto_en && (pre == PRE_W'(TICK_DIV - 1));
   assign advance = (state == SHOW) && (step || tick);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         shadow    <= '0;
         idx       <= '0;
         pre       <= '0;
         byte_q    <= '0;
         loaded_q  <= 1'b0;
         wrapped_q <= 1'b0;
      end else begin
         // Registered mux: reflects idx/shadow as they were this cycle.
         byte_q    <= block_byte(shadow, idx);
         wrapped_q <= 1'b0;
         if (bus.data_valid) begin
            // A load drops any coincident advance, so no wrapped pulse either.
            state    <= SHOW;
            shadow   <= bus.data_in;
            idx      <= '0;
            pre      <= '0;
            loaded_q <= 1'b1;
         end else if (state == SHOW) begin
            if (advance) begin
               idx       <= idx + 1'b1;
               wrapped_q <= (idx == IDX_W'(NUM_BYTES - 1));
            end
            // A manual step restarts the period so the next tick is a full
            // TICK_DIV away; auto_en low parks the prescaler at zero.
            if (step || tick || !bus.auto_en) begin
               pre <= '0;
            end else begin
               pre <= pre + 1'b1;
            end
         end
      end
   end

   assign bus.byte_out = byte_q;
   assign bus.byte_idx = idx;
   assign bus.loaded   = loaded_q;
   assign bus.wrapped  = wrapped_q;

endmodule

// File: tb/tb_aes_byte_scanner.sv
// Scoreboard bench for aes_byte_scanner with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// Latency: model pushes expected outputs at each posedge, monitor compares at negedge.
// Backpressure: n/a.
module tb_aes_byte_scanner;

   localparam int TDIV = 4;
   localparam int DB   = 3;
   localparam int MAXC = 8000;
   localparam int WAIT_LIMIT = 300;

   typedef struct packed {
      logic [7:0] bo;
      logic [3:0] idx;
      logic       ld;
      logic       wr;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aes_byte_scanner_if bus();

   aes_byte_scanner #(
      .TICK_DIV        (TDIV),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int passes = 0;
   int fails_printed = 0;
   int wrap_seen = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else begin
         if (fails_printed < 40)
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
         fails_printed++;
      end
   endtask

   // ---------------- behavioural reference model ----------------
   exp_t         expq[$];
   int           t = 0;
   bit           rawh  [0:MAXC+4];   // raw button as sampled at each edge
   bit           stepe [0:MAXC+4];   // edges at which a button step applies
   bit           m_show = 0;
   int           m_idx = 0;
   int           m_cnt = 0;
   logic [127:0] m_shadow = '0;
   bit           m_lvl = 0;
   int           m_last_rst = -100;
   exp_t         m_out;
   logic [127:0] m_tmp;
   bit           m_acc, m_tick, m_step;

   always @(posedge clk) begin
      m_tmp = m_shadow >> (8 * (15 - m_idx));
      m_out.bo = m_tmp[7:0];
      m_out.wr = 1'b0;
      if (rst) begin
         m_show = 0; m_idx = 0; m_cnt = 0; m_shadow = '0; m_lvl = 0;
         m_last_rst = t;
         // the synchroniser is cleared, so the two raw samples in flight are lost
         rawh[t] = 0;
         if (t > 0) rawh[t-1] = 0;
         stepe[t+1] = 0; stepe[t+2] = 0;
         m_out.bo = 8'h00;
      end else begin
         rawh[t] = bus.step_btn;
         // accepted level flips once the last DB synchronised samples (raw
         // delayed by 2) all differ from it, counting only since reset
         m_acc = (t >= DB + 1) && (t - DB + 1 > m_last_rst);
         for (int k = 0; k < DB; k++)
            if (m_acc && rawh[t-2-k] == m_lvl) m_acc = 0;
         if (m_acc) begin
            m_lvl = !m_lvl;
            if (m_lvl) stepe[t+2] = 1;   // edge pulse next cycle, applied the one after
         end
         m_step = stepe[t];
         m_tick = m_show && bus.auto_en && (m_cnt == TDIV - 1);
         if (bus.data_valid) begin
            m_shadow = bus.data_in; m_idx = 0; m_cnt = 0; m_show = 1;
         end else if (m_show) begin
            if (m_step || m_tick) begin
               m_out.wr = (m_idx == 15);
               m_idx = (m_idx + 1) % 16;
            end
            if (m_step || m_tick || !bus.auto_en) m_cnt = 0;
            else m_cnt = m_cnt + 1;
         end
      end
      m_out.idx = m_idx[3:0];
      m_out.ld  = m_show;
      expq.push_back(m_out);
      if (t < MAXC) t++;
   end

   // ---------------- monitor ----------------
   exp_t mon_e;
   always @(negedge clk) begin
      if (expq.size() > 0) begin
         mon_e = expq.pop_front();
         check("outputs{byte,idx,loaded,wrapped}",
               {50'd0, bus.byte_out, bus.byte_idx, bus.loaded, bus.wrapped}, {50'd0, mon_e});
         if (bus.wrapped === 1'b1) wrap_seen++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive_cycle();
      @(posedge clk); #1;
   endtask

   // Returns at the first negedge where byte_idx equals v.
   task automatic wait_idx(input logic [3:0] v);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.byte_idx !== v && n < WAIT_LIMIT);
      check("wait_idx_timeout", {63'd0, n >= WAIT_LIMIT}, 64'd0);
   endtask

   int   w0;
   int   hold;
   logic btn_r;

   initial begin
      rst = 1'b1;
      bus.data_in = '0; bus.data_valid = 1'b0; bus.step_btn = 1'b0; bus.auto_en = 1'b0;
      repeat (3) drive_cycle();
      rst = 1'b0;

      // 1: no block loaded, auto on, button pressed: nothing moves
      bus.auto_en = 1'b1; bus.step_btn = 1'b1;
      repeat (10) drive_cycle();
      bus.step_btn = 1'b0;
      repeat (40) drive_cycle();
      @(negedge clk);
      check("empty_loaded", {63'd0, bus.loaded}, 64'd0);
      check("empty_idx", {60'd0, bus.byte_idx}, 64'd0);

      // 2: load pattern with auto tick, full scan with one wrap
      drive_cycle();
      bus.data_in = 128'h00112233_44556677_8899AABB_CCDDEEFF; bus.data_valid = 1'b1;
      drive_cycle();
      bus.data_valid = 1'b0;
      w0 = wrap_seen;
      @(negedge clk);
      check("load_loaded", {63'd0, bus.loaded}, 64'd1);
      repeat (66) @(negedge clk);
      check("scan_wrap_count", 64'(wrap_seen - w0), 64'd1);

      // 3: manual step with bounce 1-0-1, auto off
      bus.auto_en = 1'b0;
      drive_cycle();
      bus.data_valid = 1'b1;
      drive_cycle();
      bus.data_valid = 1'b0;
      bus.step_btn = 1'b1; drive_cycle();
      bus.step_btn = 1'b0; drive_cycle();
      bus.step_btn = 1'b1;                 // last bounce edge: step pulse 6 cycles on
      repeat (7) @(negedge clk);
      check("step_not_early_idx", {60'd0, bus.byte_idx}, 64'd0);
      @(negedge clk);
      check("step_idx", {60'd0, bus.byte_idx}, 64'd1);
      @(negedge clk);
      check("step_byte", {56'd0, bus.byte_out}, 64'h11);
      repeat (9) drive_cycle();
      bus.step_btn = 1'b0;
      repeat (10) @(negedge clk);
      check("release_no_step_idx", {60'd0, bus.byte_idx}, 64'd1);
      check("release_byte", {56'd0, bus.byte_out}, 64'h11);

      // 4: step and tick coincide on the tick leaving idx=5
      bus.auto_en = 1'b1;
      wait_idx(4'd4);
      drive_cycle();
      bus.step_btn = 1'b1;
      repeat (8) @(negedge clk);
      check("coincide_idx", {60'd0, bus.byte_idx}, 64'd6);
      repeat (3) @(negedge clk);
      check("post_step_full_period", {60'd0, bus.byte_idx}, 64'd6);
      @(negedge clk);
      check("post_step_tick", {60'd0, bus.byte_idx}, 64'd7);
      bus.step_btn = 1'b0;

      // 5: load in the same cycle as a tick at idx=15
      wait_idx(4'd15);
      repeat (3) drive_cycle();
      bus.data_in = 128'hA55A0102_03040506_0708090A_0B0C0D0E; bus.data_valid = 1'b1;
      drive_cycle();
      bus.data_valid = 1'b0;
      @(negedge clk);
      check("load_vs_tick_idx", {60'd0, bus.byte_idx}, 64'd0);
      check("load_vs_tick_nowrap", {63'd0, bus.wrapped}, 64'd0);
      @(negedge clk);
      check("load_vs_tick_byte", {56'd0, bus.byte_out}, 64'hA5);

      // 6: reset mid-scan at idx=9
      wait_idx(4'd9);
      drive_cycle();
      rst = 1'b1;
      drive_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("rst_outputs", {50'd0, bus.byte_out, bus.byte_idx, bus.loaded, bus.wrapped}, 64'd0);
      repeat (12) @(negedge clk);
      check("rst_ticks_ignored_idx", {60'd0, bus.byte_idx}, 64'd0);
      check("rst_loaded", {63'd0, bus.loaded}, 64'd0);

      // 7: randomised traffic against the model
      hold = 0; btn_r = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         drive_cycle();
         bus.data_valid = ($urandom_range(0, 39) == 0);
         bus.data_in = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 29) == 0) bus.auto_en = ~bus.auto_en;
         if (hold == 0) begin
            btn_r = ~btn_r;
            hold = $urandom_range(1, 10);
         end else hold--;
         bus.step_btn = btn_r;
         rst = ($urandom_range(0, 299) == 0);
      end
      drive_cycle();
      rst = 1'b0; bus.data_valid = 1'b0;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
